// File: rtl/rsff_bank_arb.sv
// rtl/rsff_bank_arb.sv - round-robin arbiter/pulse sequencer sharing one RS flip-flop bank
// Optional Q readback verification (o_err) enabled by macro RSFF_ARB_VERIFY_EN.
module rsff_bank_arb #(
    parameter int N       = 2,
    parameter int W       = 4,
    parameter int PULSE_W = 2,
    parameter int RECOV   = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_req,
    input  logic [N*W-1:0] i_cmd_s,
    input  logic [N*W-1:0] i_cmd_r,
    output logic [N-1:0]   o_ack,
    output logic [2:0]     o_gnt_id,
    output logic           o_busy,
    output logic [W-1:0]   o_r,
    output logic [W-1:0]   o_s,
`ifdef RSFF_ARB_VERIFY_EN
    output logic           o_err,
`endif
    input  logic [W-1:0]   i_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        r_state, w_state;
    logic [15:0]   r_cnt, w_cnt;
    logic [2:0]    r_ptr, w_ptr;
    logic [2:0]    r_gnt, w_gnt;
    logic [N-1:0]  r_ack, w_ack;
    logic [W-1:0]  r_r, w_r;
    logic [W-1:0]  r_s, w_s;
    logic          r_busy, w_busy;
    logic [W-1:0]  r_rm, w_rm;
    logic [W-1:0]  r_sm, w_sm;

    logic          w_found;
    logic [2:0]    w_win;
    logic [3:0]    w_idx;
    logic [W-1:0]  w_sel_r;
    logic [W-1:0]  w_sel_s;
    logic [N-1:0]  w_gnt_oh;

    // Round-robin search starting at r_ptr, wrapping modulo N
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + 4'(k);
            if (w_idx >= 4'(N)) begin
                w_idx = w_idx - 4'(N);
            end
            for (int j = 0; j < N; j++) begin
                if (!w_found && (w_idx == 4'(j)) && i_req[j]) begin
                    w_found = 1'b1;
                    w_win   = 3'(j);
                end
            end
        end
    end

    always_comb begin
        w_sel_r  = '0;
        w_sel_s  = '0;
        w_gnt_oh = '0;
        for (int j = 0; j < N; j++) begin
            if (w_win == 3'(j)) begin
                w_sel_r = i_cmd_r[j*W +: W];
                w_sel_s = i_cmd_s[j*W +: W];
            end
            if (r_gnt == 3'(j)) begin
                w_gnt_oh[j] = 1'b1;
            end
        end
    end

    // Reset mask wins on conflicting bits so R and S are never both high
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_ptr   = r_ptr;
        w_gnt   = r_gnt;
        w_rm    = r_rm;
        w_sm    = r_sm;
        w_ack   = '0;
        w_r     = '0;
        w_s     = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state = DRIVE;
                    w_cnt   = '0;
                    w_gnt   = w_win;
                    w_ptr   = (w_win == 3'(N-1)) ? 3'd0 : w_win + 3'd1;
                    w_rm    = w_sel_r;
                    w_sm    = w_sel_s & ~w_sel_r;
                    w_r     = w_rm;
                    w_s     = w_sm;
                end
            end
            DRIVE: begin
                if (r_cnt == 16'(PULSE_W-1)) begin
                    w_state = HOLD;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                    w_r   = r_rm;
                    w_s   = r_sm;
                end
            end
            HOLD: begin
                if (r_cnt == 16'(RECOV-1)) begin
                    w_state = DONE;
                    w_ack   = w_gnt_oh;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
        w_busy = (w_state != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_r     <= '0;
            r_s     <= '0;
            r_busy  <= 1'b0;
            r_rm    <= '0;
            r_sm    <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ptr   <= w_ptr;
            r_gnt   <= w_gnt;
            r_ack   <= w_ack;
            r_r     <= w_r;
            r_s     <= w_s;
            r_busy  <= w_busy;
            r_rm    <= w_rm;
            r_sm    <= w_sm;
        end
    end

`ifdef RSFF_ARB_VERIFY_EN
    logic [W-1:0] r_qpre, w_qpre;
    logic         r_err, w_err;

    // Expected bank state after the pulse: pre-grant state with Rm cleared and Sm set
    always_comb begin
        w_qpre = r_qpre;
        if ((r_state == IDLE) && w_found) begin
            w_qpre = i_q;
        end
        w_err = r_err;
        if ((r_state == DONE) && (i_q != ((r_qpre & ~r_rm) | r_sm))) begin
            w_err = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_qpre <= '0;
            r_err  <= 1'b0;
        end else begin
            r_qpre <= w_qpre;
            r_err  <= w_err;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_q;
    assign w_unused_q = ^i_q;
`endif

    assign o_ack    = r_ack;
    assign o_gnt_id = r_gnt;
    assign o_busy   = r_busy;
    assign o_r      = r_r;
    assign o_s      = r_s;

endmodule

// File: tb/tb_rsff_bank_arb.sv
// tb/tb_rsff_bank_arb.sv - directed scoreboard bench for rsff_bank_arb (N=2, W=4)
module tb_rsff_bank_arb;

    typedef struct packed {
        logic [2:0] id;
        logic [3:0] r;
        logic [3:0] s;
    } exp_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [1:0] req     = 2'b00;
    logic [7:0] cmd_s   = 8'h00;
    logic [7:0] cmd_r   = 8'h00;
    logic       q_force = 1'b0;
    logic [1:0] ack;
    logic [2:0] gnt;
    logic       busy;
    logic [3:0] r;
    logic [3:0] s;
    logic [3:0] q_bank;
    logic [3:0] q_in;
`ifdef RSFF_ARB_VERIFY_EN
    logic       err;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // RS bank model: reset bits clear, set bits set, on each rising edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_bank <= 4'b0000;
        else        q_bank <= (q_bank & ~r) | s;
    end
    assign q_in = q_force ? 4'b0000 : q_bank;

    rsff_bank_arb #(.N(2), .W(4), .PULSE_W(2), .RECOV(1)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_cmd_s  (cmd_s),
        .i_cmd_r  (cmd_r),
        .o_ack    (ack),
        .o_gnt_id (gnt),
        .o_busy   (busy),
        .o_r      (r),
        .o_s      (s),
`ifdef RSFF_ARB_VERIFY_EN
        .o_err    (err),
`endif
        .i_q      (q_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        chk("r_and_s_zero", 32'(r & s), 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] id, input logic [3:0] rm, input logic [3:0] sm);
        exp_t e;
        e.id = id;
        e.r  = rm;
        e.s  = sm;
        sb.push_back(e);
    endtask

    task automatic wait_grant(output exp_t e);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("grant_seen", 32'(busy), 32'd1);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("gnt_id", 32'(gnt), 32'(e.id));
        chk("drive1_r", 32'(r), 32'(e.r));
        chk("drive1_s", 32'(s), 32'(e.s));
        chk("drive1_ack", 32'(ack), 32'd0);
    endtask

    task automatic finish_txn(input exp_t e);
        logic [1:0] oh;
        oh = 2'b00;
        oh[e.id[0]] = 1'b1;
        tick();
        chk("drive2_r", 32'(r), 32'(e.r));
        chk("drive2_s", 32'(s), 32'(e.s));
        tick();
        chk("hold_r", 32'(r), 32'd0);
        chk("hold_s", 32'(s), 32'd0);
        chk("hold_ack", 32'(ack), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        tick();
        chk("done_ack", 32'(ack), 32'(oh));
        tick();
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt_hold", 32'(gnt), 32'(e.id));
    endtask

    task automatic txn();
        exp_t e;
        wait_grant(e);
        finish_txn(e);
    endtask

    initial begin
        exp_t e;
        // Reset held with both requests pending: nothing may happen
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_r", 32'(r), 32'd0);
            chk("rst_s", 32'(s), 32'd0);
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_gnt", 32'(gnt), 32'd0);
        end

        req = 2'b01;
        cmd_s[3:0] = 4'b0011;
        cmd_r[3:0] = 4'b0100;
        push(3'd0, 4'b0100, 4'b0011);
        rst_n = 1'b1;
        txn();
        req = 2'b00;
        chk("q_after_first", 32'(q_bank), 32'h3);

        // Conflicting bit 3: reset wins
        cmd_s[3:0] = 4'b1010;
        cmd_r[3:0] = 4'b1000;
        push(3'd0, 4'b1000, 4'b0010);
        req = 2'b01;
        txn();
        req = 2'b00;
        chk("q_after_conflict", 32'(q_bank), 32'h3);

        cmd_s[7:4] = 4'b0100;
        cmd_r[7:4] = 4'b0001;
        push(3'd1, 4'b0001, 4'b0100);
        req = 2'b10;
        txn();

        req = 2'b11;
        push(3'd0, 4'b1000, 4'b0010);
        push(3'd1, 4'b0001, 4'b0100);
        push(3'd0, 4'b1000, 4'b0010);
        push(3'd1, 4'b0001, 4'b0100);
        for (int i = 0; i < 4; i++) txn();
        req = 2'b00;

        cmd_s[7:4] = 4'b0000;
        cmd_r[7:4] = 4'b0000;
        push(3'd1, 4'b0000, 4'b0000);
        req = 2'b10;
        txn();

        // Reset during second DRIVE cycle after granting 0 (pointer would be 1)
        cmd_s[3:0] = 4'b0001;
        cmd_r[3:0] = 4'b0010;
        req = 2'b11;
        push(3'd0, 4'b0010, 4'b0001);
        wait_grant(e);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_r", 32'(r), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        tick();
        chk("midrst_ack", 32'(ack), 32'd0);
        rst_n = 1'b1;
        push(3'd0, 4'b0010, 4'b0001);
        wait_grant(e);
        cmd_s[3:0] = 4'b1111;
        cmd_r[3:0] = 4'b0000;
        finish_txn(e);
        req = 2'b00;

`ifdef RSFF_ARB_VERIFY_EN
        chk("err_clear", 32'(err), 32'd0);
        q_force = 1'b1;
        cmd_s[3:0] = 4'b0001;
        cmd_r[3:0] = 4'b0000;
        push(3'd0, 4'b0000, 4'b0001);
        req = 2'b01;
        txn();
        req = 2'b00;
        chk("err_set", 32'(err), 32'd1);
        q_force = 1'b0;
        push(3'd0, 4'b0000, 4'b0001);
        req = 2'b01;
        txn();
        req = 2'b00;
        chk("err_sticky", 32'(err), 32'd1);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
